// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
// PROGRAM_LOADER_CHECKSUM_EN adds the CHECK state.
package program_loader_pkg;

   localparam logic [31:0] PL_BASE_ADDRESS = 32'h0040_0000;
   localparam int          PL_LEN_W        = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_DONE,
      ST_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      , ST_CHECK
`endif
   } pl_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; o_word_valid marks
// the cycle in which the 4th byte is being accepted (o_word is complete then).
module loader_word_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clear,
   input  logic        i_byte_en,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   logic [1:0]  r_lane;
   logic [23:0] r_shift;

   assign o_word_valid = i_byte_en && (r_lane == 2'd3);
   assign o_word       = {i_byte, r_shift};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane  <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_clear) begin
         r_lane  <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_byte_en) begin
         r_lane  <= r_lane + 2'd1;
         r_shift <= {i_byte, r_shift[23:8]};
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it to program
// memory and releases the CPU. Optional PROGRAM_LOADER_CHECKSUM_EN trailer.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int          MEMORY_DEPTH = 32,
   parameter int          DATA_WIDTH   = 32,
   parameter logic [31:0] BASE_ADDRESS = PL_BASE_ADDRESS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start_i,
   input  logic [7:0]            Byte_Data_i,
   input  logic                  Byte_Valid_i,
   output logic                  Byte_Ready_o,
   output logic                  Write_Enable_o,
   output logic [DATA_WIDTH-1:0] Write_Address_o,
   output logic [DATA_WIDTH-1:0] Write_Data_o,
   output logic                  Cpu_Reset_n_o,
   output logic                  Done_o,
   output logic                  Error_o
);

   localparam int               IDX_W   = $clog2(MEMORY_DEPTH) + 1;
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   pl_state_t               r_state;
   pl_state_t               w_next;
   logic                    r_ready;
   logic                    r_we;
   logic [DATA_WIDTH-1:0]   r_wr_addr;
   logic [DATA_WIDTH-1:0]   r_wr_data;
   logic                    r_done;
   logic                    r_error;
   logic                    r_cpu_rst_n;
   logic [PL_LEN_W-1:0]     r_len;
   logic [IDX_W-1:0]        r_word_idx;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]              r_sum;
`endif

   logic                    w_accept;
   logic                    w_start_load;
   logic                    w_next_ready;
   logic [PL_LEN_W-1:0]     w_len;
   logic                    w_last_word;
   logic                    w_word_valid;
   logic [31:0]             w_word;

   assign w_accept     = Byte_Valid_i && r_ready;
   assign w_start_load = Start_i &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));
   assign w_len        = {Byte_Data_i, r_len[7:0]};
   assign w_last_word  = ((PL_LEN_W'(r_word_idx) + 16'd1) == r_len);

   loader_word_assembler u_asm (
      .clk          (clk),
      .rst_n        (reset),
      .i_clear      (w_start_load),
      .i_byte_en    (w_accept && (r_state == ST_DATA)),
      .i_byte       (Byte_Data_i),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: if (Start_i) w_next = ST_LEN_LO;
         ST_LEN_LO: if (w_accept) w_next = ST_LEN_HI;
         ST_LEN_HI: begin
            if (w_accept)
               w_next = ((w_len == '0) || (w_len > PL_LEN_W'(MEMORY_DEPTH))) ? ST_ERROR : ST_DATA;
         end
         ST_DATA: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (w_word_valid && w_last_word) w_next = ST_CHECK;
`else
            if (w_word_valid && w_last_word) w_next = ST_DONE;
`endif
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         ST_CHECK: if (w_accept) w_next = (Byte_Data_i == r_sum) ? ST_DONE : ST_ERROR;
`endif
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_next_ready = (w_next == ST_LEN_LO) || (w_next == ST_LEN_HI) || (w_next == ST_DATA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (w_next == ST_CHECK) w_next_ready = 1'b1;
`endif
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_ready     <= 1'b0;
         r_we        <= 1'b0;
         r_wr_addr   <= DATA_WIDTH'(BASE_ADDRESS);
         r_wr_data   <= '0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_cpu_rst_n <= 1'b0;
         r_len       <= '0;
         r_word_idx  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         r_sum       <= 8'd0;
`endif
      end else begin
         r_state     <= w_next;
         r_ready     <= w_next_ready;
         r_done      <= (w_next == ST_DONE);
         r_error     <= (w_next == ST_ERROR);
         r_cpu_rst_n <= (w_next == ST_DONE);
         r_we        <= 1'b0;
         if (w_start_load) begin
            r_len      <= '0;
            r_word_idx <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_sum      <= 8'd0;
`endif
         end
         if (w_accept && (r_state == ST_LEN_LO)) r_len[7:0] <= Byte_Data_i;
         if (w_accept && (r_state == ST_LEN_HI)) begin
            r_len[15:8] <= Byte_Data_i;
            r_word_idx  <= '0;
         end
         if (r_state == ST_DATA) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (w_accept) r_sum <= r_sum + Byte_Data_i;
`endif
            if (w_word_valid) begin
               r_we       <= 1'b1;
               r_wr_data  <= DATA_WIDTH'(w_word);
               r_wr_addr  <= DATA_WIDTH'(BASE_ADDRESS) + (DATA_WIDTH'(r_word_idx) << 2);
               r_word_idx <= w_last_word ? '0 : r_word_idx + IDX_ONE;
            end
         end
      end
   end

   assign Byte_Ready_o    = r_ready;
   assign Write_Enable_o  = r_we;
   assign Write_Address_o = r_wr_addr;
   assign Write_Data_o    = r_wr_data;
   assign Done_o          = r_done;
   assign Error_o         = r_error;
   assign Cpu_Reset_n_o   = r_cpu_rst_n;

endmodule
